// File: rtl/display_sequencer_pkg.sv
// Shared types for the display sequencer: BCD date/time record, page enum, segment constants
// and the page-to-digit layout used by the top level.
package display_sequencer_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      PAGE_TIME = 2'd0,
      PAGE_DATE = 2'd1,
      PAGE_YEAR = 2'd2,
      PAGE_SEC  = 2'd3
   } page_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef struct packed {
      bcd_t [1:0] hour;
      bcd_t [1:0] minute;
      bcd_t [1:0] second;
      bcd_t [1:0] day;
      bcd_t [1:0] month;
      bcd_t       day_of_week;
      bcd_t [1:0] year;
   } date_time_t;

   localparam int DT_W = $bits(date_time_t);

   typedef struct packed {
      logic blank;
      bcd_t val;
   } digit_t;

   function automatic digit_t bcd_dig(bcd_t v);
      return '{blank: 1'b0, val: v};
   endfunction

   // Digit idx of an 8-digit page, idx 7 being the leftmost.
   function automatic digit_t page_digit(date_time_t dt, page_t pg, logic [2:0] idx);
      digit_t row [8];
      for (int i = 0; i < 8; i++) row[i] = '{blank: 1'b1, val: 4'h0};
      case (pg)
         PAGE_TIME: begin
            row[7] = bcd_dig(dt.hour[1]);   row[6] = bcd_dig(dt.hour[0]);
            row[5] = bcd_dig(dt.minute[1]); row[4] = bcd_dig(dt.minute[0]);
            row[3] = bcd_dig(dt.second[1]); row[2] = bcd_dig(dt.second[0]);
         end
         PAGE_DATE: begin
            row[7] = bcd_dig(dt.day[1]);    row[6] = bcd_dig(dt.day[0]);
            row[5] = bcd_dig(dt.month[1]);  row[4] = bcd_dig(dt.month[0]);
            row[3] = bcd_dig(4'd0);         row[2] = bcd_dig(dt.day_of_week);
         end
         PAGE_YEAR: begin
            row[7] = bcd_dig(4'd2);         row[6] = bcd_dig(4'd0);
            row[5] = bcd_dig(dt.year[1]);   row[4] = bcd_dig(dt.year[0]);
            row[3] = bcd_dig(dt.month[1]);  row[2] = bcd_dig(dt.month[0]);
         end
         default: begin
            row[7] = bcd_dig(dt.second[1]); row[6] = bcd_dig(dt.second[0]);
         end
      endcase
      return row[idx];
   endfunction

endpackage

// File: rtl/display_sequencer_seg7_encoder.sv
// BCD digit to active-low 7-segment pattern (bit 0 = a ... bit 6 = g); combinational.
// Values above 9 show a dash, the blank flag turns every segment off.
module seg7_encoder
   import display_sequencer_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/display_sequencer.sv
// Multi-page 7-segment display sequencer (manual / auto-rotate, DCF77 sync); hex is registered one
// cycle after each clk_en snapshot. Optional error blink via `DISPLAY_SEQUENCER_BLINK_EN.
module display_sequencer
   import display_sequencer_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DWELL_TICKS = 300,
   parameter int BLINK_TICKS = 50
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clk_en,
   input  logic                    mode_auto,
   input  logic [1:0]              page_sel,
   input  logic                    sync,
   input  logic                    error,
   input  logic [DT_W-1:0]         date_time,
   output logic [NUM_DIGITS*7-1:0] hex,
   output logic [1:0]              page
);

   localparam int DW = $clog2(DWELL_TICKS);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

   logic                    mode_meta_q, mode_meta_d, mode_s_q, mode_s_d;
   logic [1:0]              sel_meta_q, sel_meta_d, sel_s_q, sel_s_d;
   page_t                   page_q, page_d;
   logic [DW-1:0]           dwell_q, dwell_d;
   logic                    pend_q, pend_d;
   date_time_t              snap_q, snap_d;
   logic                    upd_q, upd_d;
   logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
   logic [NUM_DIGITS*7-1:0] seg_w;
   logic                    blink_off;

   always_comb begin
      mode_meta_d = mode_auto;
      mode_s_d    = mode_meta_q;
      sel_meta_d  = page_sel;
      sel_s_d     = sel_meta_q;
      page_d      = page_q;
      dwell_d     = dwell_q;
      pend_d      = pend_q;
      upd_d       = clk_en;
      snap_d      = clk_en ? date_time_t'(date_time) : snap_q;
      hex_d       = upd_q ? seg_w : hex_q;
      if (!mode_s_q) begin
         pend_d = 1'b0;
         if (clk_en) begin
            page_d  = page_t'(sel_s_q);
            dwell_d = '0;
         end
      end else if (clk_en) begin
         // a sync arriving on the tick itself counts as pending, and beats a dwell wrap
         if (sync || pend_q) begin
            page_d  = PAGE_TIME;
            dwell_d = '0;
            pend_d  = 1'b0;
         end else if (dwell_q == DWELL_LAST) begin
            page_d  = page_t'(page_q + 2'd1);
            dwell_d = '0;
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end else if (sync) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_meta_q <= 1'b0;
         mode_s_q    <= 1'b0;
         sel_meta_q  <= 2'd0;
         sel_s_q     <= 2'd0;
         page_q      <= PAGE_TIME;
         dwell_q     <= '0;
         pend_q      <= 1'b0;
         snap_q      <= '0;
         upd_q       <= 1'b0;
         hex_q       <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         mode_meta_q <= mode_meta_d;
         mode_s_q    <= mode_s_d;
         sel_meta_q  <= sel_meta_d;
         sel_s_q     <= sel_s_d;
         page_q      <= page_d;
         dwell_q     <= dwell_d;
         pend_q      <= pend_d;
         snap_q      <= snap_d;
         upd_q       <= upd_d;
         hex_q       <= hex_d;
      end
   end

`ifdef DISPLAY_SEQUENCER_BLINK_EN
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q, blink_ph_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      if (!error) begin
         blink_cnt_d = '0;
         blink_ph_d  = 1'b0;
      end else if (clk_en) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end

   assign blink_off = blink_ph_q;
`else
   logic unused_error;
   assign unused_error = error;
   assign blink_off    = 1'b0;
`endif

   // Only the most-significant NUM_DIGITS digits of the 8-digit page are driven.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      digit_t dig;
      assign dig = page_digit(snap_q, page_q, 3'(8 - NUM_DIGITS + i));
      seg7_encoder u_enc (
         .bcd   (dig.val),
         .blank (dig.blank | blink_off),
         .seg   (seg_w[i*7 +: 7])
      );
   end

   assign hex  = hex_q;
   assign page = page_q;

endmodule
